// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester on-chip SRAM arbiter.
package onchip_mem_arb_pkg;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  localparam int MAX_BEATS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = OWNER_IDLE,
    ST_OWN0 = OWNER_M0,
    ST_OWN1 = OWNER_M1
  } arb_state_e;

endpackage

// File: rtl/onchip_mem_arbiter_rr_grant_fsm.sv
// Round-robin ownership FSM: owner state, beat counter and last-owner memory.
module rr_grant_fsm
  import onchip_mem_arb_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       grant0,
  output logic       grant1,
  output arb_state_e state_o
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  arb_state_e state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       last_q, last_d;

  // Next-state, beat count and last-owner update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
          count_d = 8'd0;
          last_d  = 1'b0;
        end else if (req1 && (count_q == LAST_BEAT)) begin
          state_d = ST_OWN1;
          count_d = 8'd0;
          last_d  = 1'b0;
        end else if (count_q != LAST_BEAT) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d = count_q;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
          count_d = 8'd0;
          last_d  = 1'b1;
        end else if (req0 && (count_q == LAST_BEAT)) begin
          state_d = ST_OWN0;
          count_d = 8'd0;
          last_d  = 1'b1;
        end else if (count_q != LAST_BEAT) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 8'd0;
        last_d  = 1'b1;
      end
    endcase
  end

  // State registers; last owner resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  // Accept strobes: the owner is served in every cycle it requests.
  always_comb begin
    grant0  = (state_q == ST_OWN0) && req0;
    grant1  = (state_q == ST_OWN1) && req1;
    state_o = state_q;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM front end sharing one single-port SRAM (1-cycle read latency).
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [1:0]        arb_owner
);

  logic       req0_s, req1_s, grant0_s, grant1_s;
  arb_state_e state_s;
  logic       rdv0_q, rdv0_d, rdv1_q, rdv1_d;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  rr_grant_fsm #(.MAX_BEATS(MAX_BEATS)) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0_s),
    .req1    (req1_s),
    .grant0  (grant0_s),
    .grant1  (grant1_s),
    .state_o (state_s)
  );

  // Memory-side mux; a simultaneous read+write is issued as a write.
  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (grant0_s) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end else if (grant1_s) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end else begin
      mem_chipselect = 1'b0;
    end
  end

  // Requester-side handshake and read-return qualification.
  always_comb begin
    m0_waitrequest = (state_s == ST_OWN0) ? ~req0_s : 1'b1;
    m1_waitrequest = (state_s == ST_OWN1) ? ~req1_s : 1'b1;
    rdv0_d         = grant0_s & m0_read & ~m0_write;
    rdv1_d         = grant1_s & m1_read & ~m1_write;
    m0_readdata    = mem_readdata;
    m1_readdata    = mem_readdata;
    m0_readdatavalid = rdv0_q;
    m1_readdatavalid = rdv1_q;
    mem_clken      = 1'b1;
    arb_owner      = state_s;
  end

  // Readdatavalid pipeline matching the RAM's one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv0_q <= 1'b0;
      rdv1_q <= 1'b0;
    end else begin
      rdv0_q <= rdv0_d;
      rdv1_q <= rdv1_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a behavioural SRAM model.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] m0_address = 12'd0, m1_address = 12'd0;
  logic [3:0]  m0_byteenable = 4'd0, m1_byteenable = 4'd0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = 32'd0, m1_writedata = 32'd0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'd0;
  logic [1:0]  arb_owner;

  int tests = 0;
  int fails = 0;
  logic [31:0] ram [0:3071];

  onchip_mem_arbiter #(.MAX_BEATS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  // Single-port SRAM model: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [11:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // Wait (bounded) for the accept cycle, then step just past the accepting edge.
  task automatic wait_accept(input int p, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? !m0_waitrequest : !m1_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_accept"}, {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 4'd0, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n_acc, n_rdv0, n_rdv1, n_m1;
    logic [1:0] exp_own;
    logic got0;
    for (int i = 0; i < 3072; i++) ram[i] = 32'd0;

    // Reset state
    #2;
    chk("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
    chk("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
    chk("rst_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
    chk("rst_cs_wr", {30'd0, mem_chipselect, mem_write}, 32'd0);
    chk("rst_owner", {30'd0, arb_owner}, 32'd0);
    chk("clken", {31'd0, mem_clken}, 32'd1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // m0 single write then read-back
    drive(0, 1'b0, 1'b1, 12'h000, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_arb_wait", {31'd0, m0_waitrequest}, 32'd1);
    @(negedge clk);
    chk("t1_grant_wait", {31'd0, m0_waitrequest}, 32'd0);
    chk("t1_mem_wr", {30'd0, mem_chipselect, mem_write}, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h000, 4'hF, 32'd0);
    wait_accept(0, "t1_rd");
    idle_cycles(0);
    @(negedge clk);
    chk("t1_rdv0", {31'd0, m0_readdatavalid}, 32'd1);
    chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_idle", {30'd0, m1_readdatavalid, m1_waitrequest}, 32'd1);
    idle_cycles(3);

    // m1 byte-lane write over all-ones, then read back
    drive(1, 1'b0, 1'b1, 12'h7FF, 4'hF, 32'hFFFFFFFF);
    wait_accept(1, "t2_w1");
    drive(1, 1'b0, 1'b1, 12'h7FF, 4'b0101, 32'h11223344);
    wait_accept(1, "t2_w2");
    drive(1, 1'b1, 1'b0, 12'h7FF, 4'hF, 32'd0);
    wait_accept(1, "t2_rd");
    idle_cycles(0);
    @(negedge clk);
    chk("t2_rdv1", {31'd0, m1_readdatavalid}, 32'd1);
    chk("t2_rdata", m1_readdata, 32'hFF22FF44);
    idle_cycles(3);

    // Both stream reads from reset: 8/8 alternation, zero-bubble handover
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h000, 4'hF, 32'd0);
    drive(1, 1'b1, 1'b0, 12'h7FF, 4'hF, 32'd0);
    n_acc = 0; n_rdv0 = 0; n_rdv1 = 0;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (c == 0) exp_own = 2'b00;
      else if ((((c - 1) / 8) % 2) == 0) exp_own = 2'b01;
      else exp_own = 2'b10;
      chk($sformatf("t3_owner_c%0d", c), {30'd0, arb_owner}, {30'd0, exp_own});
      if (c >= 1 && (!m0_waitrequest || !m1_waitrequest)) n_acc++;
      if (c >= 2 && c <= 17) begin
        n_rdv0 += int'(m0_readdatavalid);
        n_rdv1 += int'(m1_readdatavalid);
      end
    end
    chk("t3_accepts", n_acc, 32'd32);
    chk("t3_rdv0_win", n_rdv0, 32'd8);
    chk("t3_rdv1_win", n_rdv1, 32'd8);
    @(posedge clk); #1;
    idle_cycles(3);

    // m1 alone for 20 accepts, then m0 raised with m1 count saturated
    drive(1, 1'b1, 1'b0, 12'h004, 4'hF, 32'd0);
    n_m1 = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (!m1_waitrequest) n_m1++;
    end
    chk("t4_m1_alone", n_m1, 32'd20);
    chk("t4_owner", {30'd0, arb_owner}, 32'd2);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h008, 4'hF, 32'd0);
    n_m1 = 0; got0 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!m0_waitrequest) begin
        got0 = 1'b1;
        break;
      end
      if (!m1_waitrequest) n_m1++;
    end
    chk("t4_m0_granted", {31'd0, got0}, 32'd1);
    chk("t4_m1_extra", n_m1, 32'd1);
    @(posedge clk); #1;
    idle_cycles(3);

    // m0 read+write together: treated as write, no readdatavalid
    drive(0, 1'b1, 1'b1, 12'h010, 4'hF, 32'hCAFEF00D);
    wait_accept(0, "t5_rw");
    idle_cycles(0);
    @(negedge clk);
    chk("t5_no_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
    chk("t5_ram", ram[16], 32'hCAFEF00D);
    idle_cycles(3);

    // Reset right after an accepted m1 read drops the pending readdatavalid
    drive(1, 1'b1, 1'b0, 12'h7FF, 4'hF, 32'd0);
    wait_accept(1, "t6_rd");
    reset_n = 1'b0;
    #1;
    chk("t6_rdv1_rst", {31'd0, m1_readdatavalid}, 32'd0);
    chk("t6_owner_rst", {30'd0, arb_owner}, 32'd0);
    chk("t6_waits_rst", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
    @(negedge clk);
    chk("t6_cs_rst", {31'd0, mem_chipselect}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rdv1_after", {31'd0, m1_readdatavalid}, 32'd0);
    chk("t6_owner_after", {30'd0, arb_owner}, 32'd2);
    @(posedge clk); #1;
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-port on-chip SRAM (32-bit, 3072 words, 12-bit word address, byte enables, one-cycle read latency).
- Requester 0 is the Nios II data master; requester 1 is the LT24 frame/pixel fetch engine.
- Presents an Avalon-MM slave with waitrequest/readdatavalid to each requester, and drives the memory's address/byteenable/chipselect/write/writedata/clken inputs.
- A beat-limit counter prevents either requester from starving the other.

Parameters:
- ADDR_W, 12, word address width of memory and requester ports.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8 (localparam).
- MAX_BEATS, 8, maximum consecutive accepted transfers for one owner while the other requester is waiting; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address, m1_address  in  ADDR_W  requester word address.
- m0_byteenable, m1_byteenable  in  BE_W  requester byte enables.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request.
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_waitrequest, m1_waitrequest  out  1  high = transfer not accepted this cycle.
- m0_readdata, m1_readdata  out  DATA_W  read data, valid when readdatavalid is high.
- m0_readdatavalid, m1_readdatavalid  out  1  one-cycle read-return strobe.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  BE_W  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_readdata  in  DATA_W  from RAM readdata.
- arb_owner  out  2  debug: 00 idle, 01 m0, 10 m1.

Behaviour:
- Request: reqN = mN_read | mN_write. If both are high, the transfer is a write; no readdatavalid is produced.
- FSM states: IDLE, OWN0, OWN1. State, beat count (8 bit), last_owner bit and readdatavalid pipeline are all registered.
- Reset values: state IDLE, count 0, last_owner 1 (so m0 wins the first tie), both waitrequest 1, both readdatavalid 0, mem_chipselect 0, mem_write 0, arb_owner 00.
- IDLE: all waitrequest high; memory idle.
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - both -> owner opposite last_owner.
  - Arbitration costs exactly one cycle.
- OWNx, accept and waitrequest:
  - mx_waitrequest = ~reqx (low whenever the owner requests); non-owner waitrequest stays 1.
  - Accept = reqx in OWNx. On accept: mem_chipselect=1, mem_address/byteenable/writedata muxed from mx, mem_write = mx_write, count++.
- OWNx, transitions (priority order):
  - ~reqx & reqy -> OWNy, count 0.
  - ~reqx & ~reqy -> IDLE, count 0.
  - reqx & reqy & count==MAX_BEATS-1 -> OWNy, count 0; this cycle's beat still completes.
  - Otherwise stay.
  - Any exit sets last_owner=x. Handover is zero-bubble.
- Counter: count saturates only by the handover rule. With the other requester idle, the owner streams indefinitely and count holds at MAX_BEATS-1.
- Read latency:
  - mx_readdatavalid is registered: high exactly one cycle after an accepted read from mx.
  - mN_readdata = mem_readdata combinationally for both ports; consumers qualify with readdatavalid.
  - Back-to-back reads give one read-data word per cycle.
- Read-after-write at the same address in consecutive cycles returns the new data (RAM port behaviour); the arbiter adds no forwarding.
- Reset asserted mid-operation: immediate return to reset values; an in-flight readdatavalid is dropped; a write accepted in the reset cycle is not guaranteed.
- arb_owner reflects the registered state.

Decomposition:
- Package onchip_mem_arb_pkg: state enum (IDLE/OWN0/OWN1), owner encoding constants, default MAX_BEATS.
- One natural sub-module: rr_grant_fsm (state, count, last_owner, grant outputs).
- Datapath muxing and the readdatavalid pipeline stay in the top.

Test Plan:
- Single m0 write 0x000=0xDEADBEEF (be=1111), then read 0x000 -> m0_waitrequest low on the cycle after request; m0_readdatavalid one cycle after read accept with readdata 0xDEADBEEF; m1 outputs idle.
- Byte-lane write m1 to 0x7FF, data 0x11223344, be=0101, over prior 0xFFFFFFFF; read back -> 0xFF22FF44.
- Both requesters stream reads continuously from reset, MAX_BEATS=8 -> first tie goes to m0; grants alternate as 8 m0 beats then 8 m1 beats, no idle cycle at handover; each port gets exactly 8 readdatavalid pulses per 16-cycle window.
- m1 requests alone for 20 cycles -> 20 accepts, no handover; m0 raised mid-stream -> m0 granted after at most MAX_BEATS more m1 beats.
- Simultaneous read+write from m0 at 0x010 -> memory written; no m0_readdatavalid.
- reset_n pulsed low the cycle after an accepted m1 read -> m1_readdatavalid stays 0; arb_owner=00, both waitrequest=1 during reset.
